// File: rtl/cache_repl_ctrl_pkg.sv
// Shared types and sizing constants for the cache replacement controller.
// Build option CACHE_REPL_INV_FIRST_EN is consumed by cache_repl_ctrl, not here.
package cache_repl_pkg;

  localparam int CACHE_ASSOC = 4;
  localparam int CACHE_SETS  = 64;
  localparam int CACHE_IDX_W = $clog2(CACHE_SETS);

  typedef enum logic [1:0] {
    FSM_IDLE   = 2'd0,
    FSM_DECIDE = 2'd1,
    FSM_REFILL = 2'd2
  } repl_fsm_e;

  // Sized for the widest supported tree; a 2-way set only uses bit 0.
  typedef logic [CACHE_ASSOC-2:0] plru_state_t;

endpackage

// File: rtl/cache_repl_ctrl_if.sv
// Lookup, refill and completion signals between tag compare, the controller and the refill engine.
interface cache_repl_ctrl_if
  import cache_repl_pkg::*;
#(
  parameter int ASSOC_NUM = CACHE_ASSOC,
  parameter int SET_NUM   = CACHE_SETS,
  localparam int IDX_W    = $clog2(SET_NUM),
  localparam int WAY_W    = $clog2(ASSOC_NUM)
);
  logic                 req_valid;
  logic                 req_ready;
  logic [IDX_W-1:0]     req_index;
  logic [ASSOC_NUM-1:0] req_hit_way;
  logic [ASSOC_NUM-1:0] req_valid_ways;
  logic                 refill_valid;
  logic                 refill_ready;
  logic [IDX_W-1:0]     refill_index;
  logic [WAY_W-1:0]     refill_way;
  logic                 done_valid;
  logic [WAY_W-1:0]     done_way;

  modport master (
    output req_valid, req_index, req_hit_way, req_valid_ways, refill_ready,
    input  req_ready, refill_valid, refill_index, refill_way, done_valid, done_way
  );

  modport slave (
    input  req_valid, req_index, req_hit_way, req_valid_ways, refill_ready,
    output req_ready, refill_valid, refill_index, refill_way, done_valid, done_way
  );
endinterface

// File: rtl/cache_repl_ctrl_plru_tree_logic.sv
// Combinational tree-PLRU step: victim of the current state word and the word after touching a way.
module plru_tree_logic
  import cache_repl_pkg::*;
#(
  parameter int ASSOC_NUM = CACHE_ASSOC,
  localparam int WAY_W    = $clog2(ASSOC_NUM)
)(
  input  plru_state_t      i_state,
  input  logic [WAY_W-1:0] i_acc_way,
  output plru_state_t      o_next_state,
  output logic [WAY_W-1:0] o_victim
);

  if (ASSOC_NUM == 4) begin : g_four_way
    // b[0] points at the colder half, b[1]/b[2] at the colder way inside each half.
    always_comb begin
      o_next_state    = i_state;
      o_next_state[0] = ~i_acc_way[1];
      if (!i_acc_way[1]) o_next_state[1] = ~i_acc_way[0];
      else               o_next_state[2] = ~i_acc_way[0];
    end
    assign o_victim = i_state[0] ? {1'b1, i_state[2]} : {1'b0, i_state[1]};
  end else begin : g_two_way
    always_comb begin
      o_next_state    = i_state;
      o_next_state[0] = ~i_acc_way[0];
    end
    assign o_victim = i_state[0];
  end

endmodule

// File: rtl/cache_repl_ctrl.sv
// Per-set tree-PLRU replacement controller with a single outstanding lookup and refill handshake.
// Define CACHE_REPL_INV_FIRST_EN to prefer the lowest invalid way over the PLRU victim on a miss.
module cache_repl_ctrl
  import cache_repl_pkg::*;
#(
  parameter int ASSOC_NUM = CACHE_ASSOC,
  parameter int SET_NUM   = CACHE_SETS,
  localparam int IDX_W    = $clog2(SET_NUM),
  localparam int WAY_W    = $clog2(ASSOC_NUM)
)(
  input  logic              clk,
  input  logic              resetn,
  cache_repl_ctrl_if.slave  bus
);

  if (ASSOC_NUM != 2 && ASSOC_NUM != 4) begin : g_bad_assoc
    $error("cache_repl_ctrl: ASSOC_NUM must be 2 or 4");
  end
  if ((SET_NUM & (SET_NUM - 1)) != 0) begin : g_bad_sets
    $error("cache_repl_ctrl: SET_NUM must be a power of two");
  end

  localparam logic [1:0] IDLE   = FSM_IDLE;
  localparam logic [1:0] DECIDE = FSM_DECIDE;
  localparam logic [1:0] REFILL = FSM_REFILL;

  logic [1:0]       r_state;
  logic [IDX_W-1:0] r_idx;
  logic             r_hit;
  logic [WAY_W-1:0] r_hit_way;
  logic [WAY_W-1:0] r_victim;
  logic             r_ready;
  logic             r_refill_valid;
  logic             r_done_valid;
  logic [WAY_W-1:0] r_done_way;
  plru_state_t      r_plru [SET_NUM];

  logic [WAY_W-1:0] w_hit_enc;
  logic [WAY_W-1:0] w_acc_way;
  logic [WAY_W-1:0] w_plru_victim;
  logic [WAY_W-1:0] w_miss_way;
  logic             w_wr_en;
  plru_state_t      w_cur_state;
  plru_state_t      w_next_state;

  // Lowest set bit wins when the hit vector is multi-hot.
  always_comb begin
    w_hit_enc = '0;
    for (int i = ASSOC_NUM - 1; i >= 0; i--) begin
      if (bus.req_hit_way[i]) w_hit_enc = WAY_W'(i);
    end
  end

  assign w_cur_state = r_plru[r_idx];
  assign w_acc_way   = (r_state == REFILL) ? r_victim : r_hit_way;
  assign w_wr_en     = ((r_state == DECIDE) && r_hit) ||
                       ((r_state == REFILL) && bus.refill_ready);

  plru_tree_logic #(.ASSOC_NUM(ASSOC_NUM)) u_plru (
    .i_state      (w_cur_state),
    .i_acc_way    (w_acc_way),
    .o_next_state (w_next_state),
    .o_victim     (w_plru_victim)
  );

`ifdef CACHE_REPL_INV_FIRST_EN
  logic [ASSOC_NUM-1:0] r_valid_ways;
  logic [WAY_W-1:0]     w_inv_way;
  logic                 w_has_inv;

  always_comb begin
    w_inv_way = '0;
    w_has_inv = 1'b0;
    for (int i = ASSOC_NUM - 1; i >= 0; i--) begin
      if (!r_valid_ways[i]) begin
        w_inv_way = WAY_W'(i);
        w_has_inv = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                                      r_valid_ways <= '0;
    else if (r_state == IDLE && bus.req_valid && r_ready) r_valid_ways <= bus.req_valid_ways;
  end

  assign w_miss_way = w_has_inv ? w_inv_way : w_plru_victim;
`else
  assign w_miss_way = w_plru_victim;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < SET_NUM; i++) r_plru[i] <= '0;
    end else if (w_wr_en) begin
      r_plru[r_idx] <= w_next_state;
    end
  end

  // req_ready is held low for the first cycle out of reset so no lookup races the release.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state        <= IDLE;
      r_idx          <= '0;
      r_hit          <= 1'b0;
      r_hit_way      <= '0;
      r_victim       <= '0;
      r_ready        <= 1'b0;
      r_refill_valid <= 1'b0;
      r_done_valid   <= 1'b0;
      r_done_way     <= '0;
    end else begin
      r_done_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.req_valid && r_ready) begin
            r_idx        <= bus.req_index;
            r_hit        <= |bus.req_hit_way;
            r_hit_way    <= w_hit_enc;
            r_done_valid <= |bus.req_hit_way;
            r_done_way   <= w_hit_enc;
            r_ready      <= 1'b0;
            r_state      <= DECIDE;
          end else begin
            r_ready <= 1'b1;
          end
        end
        DECIDE: begin
          if (r_hit) begin
            r_ready <= 1'b1;
            r_state <= IDLE;
          end else begin
            r_victim       <= w_miss_way;
            r_refill_valid <= 1'b1;
            r_state        <= REFILL;
          end
        end
        REFILL: begin
          if (bus.refill_ready) begin
            r_refill_valid <= 1'b0;
            r_done_valid   <= 1'b1;
            r_done_way     <= r_victim;
            r_ready        <= 1'b1;
            r_state        <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready    = r_ready;
  assign bus.refill_valid = r_refill_valid;
  assign bus.refill_index = r_idx;
  assign bus.refill_way   = r_victim;
  assign bus.done_valid   = r_done_valid;
  assign bus.done_way     = r_done_way;

endmodule

// File: tb/tb_cache_repl_ctrl.sv
// Self-checking bench for cache_repl_ctrl: directed vector table, reset-in-refill sequence, random traffic vs a recency model.
module tb_cache_repl_ctrl;
  import cache_repl_pkg::*;

`ifdef CACHE_REPL_INV_FIRST_EN
  localparam bit INV_FIRST = 1'b1;
`else
  localparam bit INV_FIRST = 1'b0;
`endif

  logic clk    = 1'b0;
  logic resetn = 1'b1;
  always #5 clk = ~clk;

  cache_repl_ctrl_if #(.ASSOC_NUM(CACHE_ASSOC), .SET_NUM(CACHE_SETS)) bus ();

  cache_repl_ctrl #(.ASSOC_NUM(CACHE_ASSOC), .SET_NUM(CACHE_SETS)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;

  // Recency model: which half was touched last, and which way inside each half.
  int last_half    [CACHE_SETS];
  int last_in_half [CACHE_SETS][2];

  function automatic void model_reset();
    for (int s = 0; s < CACHE_SETS; s++) begin
      last_half[s]       = 1;
      last_in_half[s][0] = 1;
      last_in_half[s][1] = 1;
    end
  endfunction

  function automatic int model_victim(int s);
    int h;
    h = 1 - last_half[s];
    return 2 * h + (1 - last_in_half[s][h]);
  endfunction

  function automatic void model_touch(int s, int w);
    last_half[s]          = w / 2;
    last_in_half[s][w / 2] = w % 2;
  endfunction

  function automatic int expected_way(int s, logic [3:0] hit, logic [3:0] vw);
    int inv;
    inv = -1;
    for (int i = 0; i < 4; i++) if (hit[i]) return i;
    for (int i = 3; i >= 0; i--) if (!vw[i]) inv = i;
    if (INV_FIRST && inv >= 0) return inv;
    return model_victim(s);
  endfunction

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Runs one lookup from a negedge to a negedge; fixed_way < 0 means take the model's answer.
  task automatic run_txn(string tag, int idx, logic [3:0] hit, logic [3:0] vw,
                         int delay, bit poke, int fixed_way);
    int exp_way;
    int n;
    exp_way = (fixed_way >= 0) ? fixed_way : expected_way(idx, hit, vw);
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (bus.req_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL %s req_ready_timeout actual=0 expected=1", tag);
      return;
    end
    bus.req_valid      = 1'b1;
    bus.req_index      = CACHE_IDX_W'(idx);
    bus.req_hit_way    = hit;
    bus.req_valid_ways = vw;
    @(negedge clk);
    bus.req_valid = 1'b0;
    if (hit != 4'b0) begin
      check({tag, " hit_done_valid"}, int'(bus.done_valid), 1);
      check({tag, " hit_done_way"}, int'(bus.done_way), exp_way);
      check({tag, " hit_no_refill"}, int'(bus.refill_valid), 0);
    end else begin
      check({tag, " miss_no_early_done"}, int'(bus.done_valid), 0);
      check({tag, " miss_no_early_refill"}, int'(bus.refill_valid), 0);
      @(negedge clk);
      check({tag, " refill_valid"}, int'(bus.refill_valid), 1);
      check({tag, " refill_index"}, int'(bus.refill_index), idx);
      check({tag, " refill_way"}, int'(bus.refill_way), exp_way);
      for (int d = 0; d < delay; d++) begin
        if (poke && d == 1) begin
          bus.req_valid   = 1'b1;
          bus.req_index   = CACHE_IDX_W'(idx ^ 1);
          bus.req_hit_way = 4'b0001;
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
        check({tag, " hold_refill_valid"}, int'(bus.refill_valid), 1);
        check({tag, " hold_refill_index"}, int'(bus.refill_index), idx);
        check({tag, " hold_refill_way"}, int'(bus.refill_way), exp_way);
        check({tag, " hold_req_ready"}, int'(bus.req_ready), 0);
        check({tag, " hold_no_done"}, int'(bus.done_valid), 0);
      end
      bus.refill_ready = 1'b1;
      @(negedge clk);
      bus.refill_ready = 1'b0;
      check({tag, " fill_done_valid"}, int'(bus.done_valid), 1);
      check({tag, " fill_done_way"}, int'(bus.done_way), exp_way);
      check({tag, " fill_refill_drop"}, int'(bus.refill_valid), 0);
    end
    @(negedge clk);
    check({tag, " done_is_pulse"}, int'(bus.done_valid), 0);
    model_touch(idx, exp_way);
    $display("txn %s idx=%0d hit=%b vw=%b way=%0d", tag, idx, hit, vw, exp_way);
  endtask

  typedef struct {
    int         idx;
    logic [3:0] hit;
    logic [3:0] vw;
    int         delay;
    bit         poke;
    int         exp_way;
  } vec_t;

  vec_t vecs [$];

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid      = 1'b0;
    bus.req_index      = '0;
    bus.req_hit_way    = '0;
    bus.req_valid_ways = '0;
    bus.refill_ready   = 1'b0;

    vecs.push_back('{5, 4'b0000, 4'b1111, 0, 1'b0, 0});
    vecs.push_back('{5, 4'b0000, 4'b1111, 0, 1'b0, 2});
    vecs.push_back('{5, 4'b0000, 4'b1111, 0, 1'b0, 1});
    vecs.push_back('{7, 4'b0000, 4'b1111, 0, 1'b0, 0});
    vecs.push_back('{7, 4'b1000, 4'b1111, 0, 1'b0, 3});
    vecs.push_back('{7, 4'b0000, 4'b1111, 0, 1'b0, 1});
    vecs.push_back('{3, 4'b0000, 4'b1011, 0, 1'b0, INV_FIRST ? 2 : 0});
    vecs.push_back('{1, 4'b0001, 4'b1111, 0, 1'b0, 0});
    vecs.push_back('{1, 4'b0100, 4'b1111, 0, 1'b0, 2});
    vecs.push_back('{2, 4'b0000, 4'b1111, 0, 1'b0, 0});
    vecs.push_back('{9, 4'b0110, 4'b1111, 0, 1'b0, 1});
    vecs.push_back('{10, 4'b0000, 4'b1111, 5, 1'b1, 0});
    vecs.push_back('{10, 4'b0000, 4'b1111, 0, 1'b0, 2});

    #1 resetn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("reset req_ready", int'(bus.req_ready), 0);
    check("reset refill_valid", int'(bus.refill_valid), 0);
    check("reset refill_index", int'(bus.refill_index), 0);
    check("reset refill_way", int'(bus.refill_way), 0);
    check("reset done_valid", int'(bus.done_valid), 0);
    check("reset done_way", int'(bus.done_way), 0);
    resetn = 1'b1;
    model_reset();
    @(negedge clk);
    check("post_reset req_ready", int'(bus.req_ready), 1);

    foreach (vecs[i]) begin
      run_txn($sformatf("vec%0d", i), vecs[i].idx, vecs[i].hit, vecs[i].vw,
              vecs[i].delay, vecs[i].poke, vecs[i].exp_way);
    end

    // Reset while a refill is pending must drop refill_valid without waiting for a clock.
    while (bus.req_ready !== 1'b1) @(negedge clk);
    bus.req_valid      = 1'b1;
    bus.req_index      = CACHE_IDX_W'(12);
    bus.req_hit_way    = 4'b0000;
    bus.req_valid_ways = 4'b1111;
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    check("rstmid refill_valid_before", int'(bus.refill_valid), 1);
    #2 resetn = 1'b0;
    #1;
    check("rstmid refill_valid_drop", int'(bus.refill_valid), 0);
    check("rstmid req_ready", int'(bus.req_ready), 0);
    check("rstmid done_valid", int'(bus.done_valid), 0);
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    model_reset();
    run_txn("rst_a", 5, 4'b0000, 4'b1111, 0, 1'b0, 0);
    run_txn("rst_b", 12, 4'b0000, 4'b1111, 1, 1'b0, 0);
    run_txn("rst_c", 7, 4'b0000, 4'b1111, 0, 1'b0, 0);

    for (int i = 0; i < 150; i++) begin
      logic [3:0] hit;
      logic [3:0] vw;
      int         delay;
      hit   = ($urandom % 2 == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
      vw    = ($urandom % 4 == 0) ? 4'($urandom_range(0, 15)) : 4'b1111;
      delay = $urandom_range(0, 3);
      run_txn($sformatf("rnd%0d", i), $urandom_range(0, 15), hit, vw,
              delay, ($urandom % 3 == 0), -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
